// File: rtl/l2_cacheline_adaptor_if.sv
// Signal bundle between the L2 controller, the line adaptor and physical memory.
// The adaptor connects through the slave modport; the L2/memory side uses master.
interface l2_cacheline_adaptor_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
);
    logic [ADDR_W-1:0]  pmem_address_i;
    logic               pmem_read_i;
    logic               pmem_write_i;
    logic [LINE_W-1:0]  pmem_wdata_i;
    logic [LINE_W-1:0]  pmem_rdata_o;
    logic               pmem_resp_o;
    logic [ADDR_W-1:0]  mem_address_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic [BURST_W-1:0] mem_wdata_o;
    logic [BURST_W-1:0] mem_rdata_i;
    logic               mem_resp_i;

    modport slave (
        input  pmem_address_i, pmem_read_i, pmem_write_i, pmem_wdata_i, mem_rdata_i, mem_resp_i,
        output pmem_rdata_o, pmem_resp_o, mem_address_o, mem_read_o, mem_write_o, mem_wdata_o
    );

    modport master (
        output pmem_address_i, pmem_read_i, pmem_write_i, pmem_wdata_i, mem_rdata_i, mem_resp_i,
        input  pmem_rdata_o, pmem_resp_o, mem_address_o, mem_read_o, mem_write_o, mem_wdata_o
    );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Converts one L2 line read/write into a 4-beat burst on the physical-memory port.
// Optional watchdog enabled by defining L2_ADAPTOR_TIMEOUT_EN (adds timeout_err_o).
module l2_cacheline_adaptor #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
`ifdef L2_ADAPTOR_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic clk,
    input  logic rst_n,
`ifdef L2_ADAPTOR_TIMEOUT_EN
    output logic timeout_err_o,
`endif
    l2_cacheline_adaptor_if.slave bus
);
    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst, StDone} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [LINE_W-1:0]  r_buf;
    logic [LINE_W-1:0]  w_buf_d;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_d;
    logic               w_last_beat;
    logic               w_wdog_hit;

    assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));

`ifdef L2_ADAPTOR_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout_err;
    logic              w_in_burst;

    assign w_in_burst = (r_state == StRdBurst) || (r_state == StWrBurst);
    // Fires on the TIMEOUT_CYCLES-th consecutive burst cycle without a beat.
    assign w_wdog_hit = w_in_burst && !bus.mem_resp_i &&
                        (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err_o = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_in_burst && !bus.mem_resp_i && !w_wdog_hit) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_wdog_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_buf   <= w_buf_d;
            r_addr  <= w_addr_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_buf_d   = r_buf;
        w_addr_d  = r_addr;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                // Write has priority; L2 keeps a pending read asserted until it is served.
                if (bus.pmem_write_i) begin
                    w_addr_d  = {bus.pmem_address_i[ADDR_W-1:5], 5'b0};
                    w_buf_d   = bus.pmem_wdata_i;
                    w_state_d = StWrBurst;
                end else if (bus.pmem_read_i) begin
                    w_addr_d  = {bus.pmem_address_i[ADDR_W-1:5], 5'b0};
                    w_state_d = StRdBurst;
                end
            end
            StRdBurst: begin
                if (bus.mem_resp_i) begin
                    w_buf_d[BURST_W*r_cnt +: BURST_W] = bus.mem_rdata_i;
                    w_cnt_d = r_cnt + CNT_W'(1);
                    if (w_last_beat) begin
                        w_state_d = StDone;
                    end
                end else if (w_wdog_hit) begin
                    w_cnt_d   = '0;
                    w_state_d = StDone;
                end
            end
            StWrBurst: begin
                if (bus.mem_resp_i) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                    if (w_last_beat) begin
                        w_state_d = StDone;
                    end
                end else if (w_wdog_hit) begin
                    w_cnt_d   = '0;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign bus.pmem_rdata_o  = r_buf;
    assign bus.pmem_resp_o   = (r_state == StDone);
    assign bus.mem_address_o = r_addr;
    assign bus.mem_read_o    = (r_state == StRdBurst);
    assign bus.mem_write_o   = (r_state == StWrBurst);
    assign bus.mem_wdata_o   = (r_state == StWrBurst) ? r_buf[BURST_W*r_cnt +: BURST_W] : '0;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed self-checking bench for l2_cacheline_adaptor with a per-cycle memory responder.
// Define L2_ADAPTOR_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_l2_cacheline_adaptor;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned BURST_W = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    l2_cacheline_adaptor_if #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .BURST_W(BURST_W)
    ) bus ();

`ifdef L2_ADAPTOR_TIMEOUT_EN
    logic timeout_err;
`endif

    l2_cacheline_adaptor #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .BURST_W(BURST_W)
`ifdef L2_ADAPTOR_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef L2_ADAPTOR_TIMEOUT_EN
        .timeout_err_o(timeout_err),
`endif
        .bus  (bus)
    );

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Acts as memory until the first pmem_resp_o; pat bit i is mem_resp_i on burst cycle i.
    task automatic run_txn(input logic [31:0] pat, input logic [255:0] line,
                           input logic [31:0] exp_addr, output int beats, output int bursts,
                           output int resp_cyc, output logic first_wr);
        int pi;
        bit done;
        bit first;
        pi       = 0;
        done     = 1'b0;
        first    = 1'b1;
        beats    = 0;
        bursts   = 0;
        resp_cyc = -1;
        first_wr = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp_o) begin
                resp_cyc       = c;
                done           = 1'b1;
                bus.mem_resp_i = 1'b0;
            end else if (bus.mem_read_o || bus.mem_write_o) begin
                if (first) begin
                    first    = 1'b0;
                    first_wr = bus.mem_write_o;
                    check_vec("burst_addr", 256'(bus.mem_address_o), 256'(exp_addr));
                end
                bursts++;
                bus.mem_resp_i  = (pi < 32) ? pat[pi] : 1'b0;
                pi++;
                bus.mem_rdata_i = bus.mem_resp_i ? line[64*beats +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
                if (bus.mem_resp_i) begin
                    if (bus.mem_write_o) begin
                        check_vec("wdata_beat", 256'(bus.mem_wdata_o), 256'(line[64*beats +: 64]));
                    end
                    beats++;
                end
            end else begin
                bus.mem_resp_i = 1'b0;
            end
        end
        bus.mem_resp_i = 1'b0;
        check_int("resp_seen", int'(done), 1);
    endtask

    // One cycle after a DONE pulse: the pulse must be gone and no burst running.
    task automatic step_idle(input string tag);
        @(posedge clk);
        #1;
        check_int({tag, "_resp_low"}, int'(bus.pmem_resp_o), 0);
        check_int({tag, "_rd_low"}, int'(bus.mem_read_o), 0);
        check_int({tag, "_wr_low"}, int'(bus.mem_write_o), 0);
    endtask

    logic [255:0] line_a;
    logic [255:0] line_w;
    logic [255:0] line_r;
    logic [255:0] line_b;
    int           beats;
    int           bursts;
    int           resp_cyc;
    logic         first_wr;

    initial begin
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_w = {64'hD3D3_0003_0003_D3D3, 64'hD2D2_0002_0002_D2D2,
                  64'hD1D1_0001_0001_D1D1, 64'hD0D0_0000_0000_D0D0};
        line_r = {64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_0003,
                  64'hA5A5_0000_0000_0002, 64'hA5A5_0000_0000_0001};
        line_b = {64'h0BAD_CAFE_0000_0003, 64'h0BAD_CAFE_0000_0002,
                  64'h0BAD_CAFE_0000_0001, 64'h0BAD_CAFE_0000_0000};

        rst_n              = 1'b0;
        bus.pmem_address_i = '0;
        bus.pmem_read_i    = 1'b0;
        bus.pmem_write_i   = 1'b0;
        bus.pmem_wdata_i   = '0;
        bus.mem_rdata_i    = '0;
        bus.mem_resp_i     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_int("rst_resp", int'(bus.pmem_resp_o), 0);
        check_int("rst_rd", int'(bus.mem_read_o), 0);
        check_int("rst_wr", int'(bus.mem_write_o), 0);
        check_vec("rst_addr", 256'(bus.mem_address_o), 256'(0));
        check_vec("rst_wdata", 256'(bus.mem_wdata_o), 256'(0));
        check_vec("rst_rdata", bus.pmem_rdata_o, 256'(0));
`ifdef L2_ADAPTOR_TIMEOUT_EN
        check_int("rst_timeout", int'(timeout_err), 0);
`endif
        rst_n = 1'b1;

        // 1: gapless read, unaligned address
        bus.pmem_address_i = 32'h0000_1234;
        bus.pmem_read_i    = 1'b1;
        run_txn(32'hFFFF_FFFF, line_a, 32'h0000_1220, beats, bursts, resp_cyc, first_wr);
        check_int("t1_first_wr", int'(first_wr), 0);
        check_int("t1_beats", beats, 4);
        check_int("t1_resp_cyc", resp_cyc, 4);
        check_vec("t1_rdata", bus.pmem_rdata_o, line_a);
        check_int("t1_rd_low_done", int'(bus.mem_read_o), 0);
        bus.pmem_read_i = 1'b0;
        step_idle("t1");
        check_vec("t1_rdata_held", bus.pmem_rdata_o, line_a);

        // 2: write burst, beat 0 first
        bus.pmem_address_i = 32'h0000_ABCF;
        bus.pmem_wdata_i   = line_w;
        bus.pmem_write_i   = 1'b1;
        run_txn(32'hFFFF_FFFF, line_w, 32'h0000_ABC0, beats, bursts, resp_cyc, first_wr);
        check_int("t2_first_wr", int'(first_wr), 1);
        check_int("t2_beats", beats, 4);
        check_int("t2_resp_cyc", resp_cyc, 4);
        bus.pmem_write_i = 1'b0;
        step_idle("t2");

        // 3: read with stalls 1,0,0,1,1,0,1
        bus.pmem_address_i = 32'h0000_1234;
        bus.pmem_read_i    = 1'b1;
        run_txn(32'h0000_0059, line_a, 32'h0000_1220, beats, bursts, resp_cyc, first_wr);
        check_int("t3_beats", beats, 4);
        check_int("t3_bursts", bursts, 7);
        check_int("t3_resp_cyc", resp_cyc, 7);
        check_vec("t3_rdata", bus.pmem_rdata_o, line_a);
        bus.pmem_read_i = 1'b0;
        step_idle("t3");

        // 4: read and write together -> write first, then the held read
        bus.pmem_address_i = 32'h0000_3000;
        bus.pmem_wdata_i   = line_w;
        bus.pmem_write_i   = 1'b1;
        bus.pmem_read_i    = 1'b1;
        run_txn(32'hFFFF_FFFF, line_w, 32'h0000_3000, beats, bursts, resp_cyc, first_wr);
        check_int("t4a_first_wr", int'(first_wr), 1);
        check_int("t4a_beats", beats, 4);
        bus.pmem_write_i = 1'b0;
        run_txn(32'hFFFF_FFFF, line_r, 32'h0000_3000, beats, bursts, resp_cyc, first_wr);
        check_int("t4b_first_wr", int'(first_wr), 0);
        check_int("t4b_resp_cyc", resp_cyc, 5);
        check_vec("t4b_rdata", bus.pmem_rdata_o, line_r);
        bus.pmem_read_i = 1'b0;
        step_idle("t4");

        // 5: reset after two read beats, then a clean read
        bus.pmem_address_i = 32'h0000_2000;
        bus.pmem_read_i    = 1'b1;
        @(posedge clk);
        #1;
        check_int("t5_rd_start", int'(bus.mem_read_o), 1);
        for (int b = 0; b < 2; b++) begin
            bus.mem_resp_i  = 1'b1;
            bus.mem_rdata_i = line_b[64*b +: 64];
            @(posedge clk);
            #1;
        end
        rst_n           = 1'b0;
        bus.pmem_read_i = 1'b0;
        bus.mem_resp_i  = 1'b0;
        @(posedge clk);
        #1;
        check_int("t5_rd_aborted", int'(bus.mem_read_o), 0);
        check_int("t5_no_resp", int'(bus.pmem_resp_o), 0);
        check_vec("t5_buf_clr", bus.pmem_rdata_o, 256'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_int("t5_no_resp_after", int'(bus.pmem_resp_o), 0);
        bus.pmem_read_i = 1'b1;
        run_txn(32'hFFFF_FFFF, line_b, 32'h0000_2000, beats, bursts, resp_cyc, first_wr);
        check_int("t5_beats", beats, 4);
        check_vec("t5_rdata", bus.pmem_rdata_o, line_b);
        bus.pmem_read_i = 1'b0;
        step_idle("t5");

`ifdef L2_ADAPTOR_TIMEOUT_EN
        // 6: memory never answers -> watchdog after 16 burst cycles
        bus.pmem_address_i = 32'h0000_0040;
        bus.pmem_read_i    = 1'b1;
        run_txn(32'h0000_0000, line_b, 32'h0000_0040, beats, bursts, resp_cyc, first_wr);
        check_int("t6_bursts", bursts, 16);
        check_int("t6_resp_cyc", resp_cyc, 16);
        check_int("t6_beats", beats, 0);
        check_int("t6_timeout", int'(timeout_err), 1);
        bus.pmem_read_i = 1'b0;
        step_idle("t6");
        check_int("t6_timeout_sticky", int'(timeout_err), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
